// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port data RAM between CPU and loader/debug ports
module dmem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          gnt_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic       last;
    logic [1:0] lat_cnt;
    logic       grant;
    logic       win;

    // Winner selection: a lone requester wins; on a tie the port that did not go last wins
    always_comb begin
        grant = req0 | req1;
        if (req0 && req1) begin
            win = ~last;
        end else begin
            win = req1;
        end
    end

    // Access sequencer: grant, one-cycle RAM strobe, read-latency countdown, one-cycle ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            lat_cnt   <= 2'd0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
            gnt_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        ram_en    <= 1'b1;
                        ram_we    <= win ? we1 : we0;
                        ram_addr  <= win ? addr1 : addr0;
                        ram_wdata <= win ? wdata1 : wdata0;
                        gnt_id    <= win;
                        last      <= win;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        if (gnt_id) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= 2'(RD_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        if (gnt_id) begin
                            rdata1 <= ram_rdata;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= ram_rdata;
                            ack0   <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters.
- Port 0 is the CPU control FSM's load/store path. Port 1 is the loader/debug port that fills or inspects data memory while the core is halted or running.
- Round-robin arbitration, one access in flight at a time, registered RAM-side signals and a fixed, countable read latency.
- Sits between the control/datapath and the data RAM instance.

Parameters:
- AW, 8, data RAM word-address width
- DW, 32, data width
- RD_LAT, 1, RAM read latency in cycles, legal range 1..3

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req0  input  1  port 0 (CPU) access request, held until ack0
- we0  input  1  port 0 write enable (1 = store, 0 = load)
- addr0  input  AW  port 0 word address
- wdata0  input  DW  port 0 store data
- ack0  output  1  port 0 completion, one-cycle pulse
- rdata0  output  DW  port 0 load data, valid while ack0 = 1
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1 (loader/debug)
- ram_en  output  1  RAM access strobe
- ram_we  output  1  RAM write enable
- ram_addr  output  AW  RAM address
- ram_wdata  output  DW  RAM write data
- ram_rdata  input  DW  RAM read data, valid RD_LAT cycles after the ram_en cycle
- busy  output  1  access in progress (state != IDLE)
- gnt_id  output  1  port owning the current access

Behaviour:
- All outputs are registered.
- Reset (rst = 0, asynchronous) takes effect immediately: state = IDLE; ram_en, ram_we, ack0, ack1, busy = 0; ram_addr, ram_wdata, rdata0, rdata1 = 0; gnt_id = 0; last = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last.
  - On grant: latch we/addr/wdata of the winner into ram_we/ram_addr/ram_wdata; set gnt_id and last to the winner; assert ram_en and busy; go to ISSUE.
- ISSUE (exactly 1 cycle, ram_en = 1):
  - Write: go to DONE.
  - Read: load lat_cnt = RD_LAT-1 and go to WAIT.
  - ram_en and ram_we drop to 0 on leaving ISSUE.
- WAIT:
  - lat_cnt != 0: decrement lat_cnt.
  - lat_cnt == 0: capture ram_rdata into rdata[gnt_id], go to DONE.
- DONE (1 cycle): ack[gnt_id] = 1; next state IDLE, where busy = 0 and ack drops.
- Latency, with the grant edge as E0:
  - Write: ram_en high in cycle E0..E1, ack high in cycle E1..E2.
  - Read: ack high RD_LAT+1 cycles after the ram_en cycle.
  - rdata holds its value until that port's next read completes.
- Requester rule: keep req/we/addr/wdata stable until ack; drop or renew req at the edge ending the ack cycle.
  - IDLE always lasts at least one cycle, so a dropped req is never re-granted.
  - A renewed req competes normally. Two continuous requesters strictly alternate.
- Throughput: one access per 3 cycles (write) or 3+RD_LAT cycles (read).
- The requester's request fields are ignored after the grant. Changing addr/wdata mid-access has no effect on the RAM access.
- A req arriving while busy is held off (no ack) until the arbiter is back in IDLE.
- Reset mid-access aborts it: no ack, RAM strobes drop immediately, and the requester re-issues after reset.
- RD_LAT outside 1..3 is a configuration error and is not supported.

Test Plan:
- Reset, RD_LAT = 1. Port 0 write addr 0x10 data 0xDEADBEEF:
  - ram_en = ram_we = 1 for exactly one cycle with ram_addr = 0x10.
  - ack0 one cycle later, ack1 never.
- Port 0 read of 0x10 (RAM model returns 0xDEADBEEF):
  - RD_LAT = 1: ack0 two cycles after the ram_en cycle, rdata0 = 0xDEADBEEF.
  - Repeat with RD_LAT = 3: ack0 four cycles after the ram_en cycle.
- req0 and req1 asserted together from reset, both held continuously:
  - Grants alternate 0,1,0,1 (gnt_id sequence).
  - No overlapping ram_en; each ack pulses exactly one cycle.
- Port 1 read in progress, port 0 raises a write during WAIT:
  - Port 0 is not granted until after ack1 plus one IDLE cycle.
  - rdata1 is correct and rdata0 is unchanged.
- Port 0 changes addr0 from 0x20 to 0x30 the cycle after grant:
  - ram_addr stays 0x20 and the RAM writes 0x20 only.
- rst pulled low in the WAIT state of a read:
  - busy, ram_en and acks are 0 immediately.
  - After release, state is IDLE and the next tie goes to port 0.
